// File: rtl/dezigzag_buffer.sv
// Ping-pong 8x8 block buffer: zigzag-ordered coefficients in, one column per beat out; DEZIGZAG_EOB_EN adds eob_in.
// Latency: column 0 is presented one cycle after the edge that accepts a block's last coefficient.
// Backpressure: coeff_ready_out is low while the write bank still holds an unread block; columns hold while out_ready_in is low.
module dezigzag_buffer #(
    parameter int COEFF_W = 12
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [COEFF_W-1:0]   coeff_in,
    input  logic                 coeff_valid_in,
`ifdef DEZIGZAG_EOB_EN
    input  logic                 eob_in,
`endif
    output logic                 coeff_ready_out,
    output logic [8*COEFF_W-1:0] column_out,
    output logic                 valid_out,
    input  logic                 out_ready_in,
    output logic [2:0]           column_idx_out
);

    // Zigzag index -> natural position {row, col}
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic {IDLE, EMIT} state_t;

    state_t               state;
    logic [COEFF_W-1:0]   mem [2][64];
    logic [1:0]           full;
    logic                 wr_bank;
    logic                 rd_bank;
    logic [5:0]           wr_idx;
    logic                 wr_fire;
    logic                 wr_last;
    logic                 rd_release;
    logic                 load_bank;
    logic [2:0]           load_col;
    logic [8*COEFF_W-1:0] load_data;

    assign coeff_ready_out = !full[wr_bank];
    assign wr_fire         = coeff_valid_in && coeff_ready_out;
    assign rd_release      = (state == EMIT) && out_ready_in && (column_idx_out == 3'd7);
`ifdef DEZIGZAG_EOB_EN
    assign wr_last = (wr_idx == 6'd63) || eob_in;
`else
    assign wr_last = (wr_idx == 6'd63);
`endif

    // Coefficient storage carries no reset: a bank is only read once marked full.
    always_ff @(posedge clk_in) begin
        if (wr_fire) begin
            mem[wr_bank][ZZ[wr_idx]] <= coeff_in;
        end
    end

`ifdef DEZIGZAG_EOB_EN
    logic [63:0] written [2];

    // The releasing bank and the filling bank always differ, so both updates coexist.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            written[0] <= '0;
            written[1] <= '0;
        end else begin
            if (rd_release) begin
                written[rd_bank] <= '0;
            end
            if (wr_fire) begin
                written[wr_bank][ZZ[wr_idx]] <= 1'b1;
            end
        end
    end
`endif

    // Next column to present: column 0 of the current bank from IDLE, column 0 of the
    // other bank after column 7, otherwise the following column of the current bank.
    always_comb begin
        load_bank = rd_bank;
        load_col  = column_idx_out + 3'd1;
        load_data = '0;
        if (state == IDLE) begin
            load_col = 3'd0;
        end else if (column_idx_out == 3'd7) begin
            load_bank = ~rd_bank;
            load_col  = 3'd0;
        end
        for (int r = 0; r < 8; r++) begin
            load_data[COEFF_W*r +: COEFF_W] = mem[load_bank][{3'(r), load_col}];
`ifdef DEZIGZAG_EOB_EN
            if (!written[load_bank][{3'(r), load_col}]) begin
                load_data[COEFF_W*r +: COEFF_W] = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            full           <= 2'b00;
            wr_bank        <= 1'b0;
            rd_bank        <= 1'b0;
            wr_idx         <= 6'd0;
            valid_out      <= 1'b0;
            column_out     <= '0;
            column_idx_out <= 3'd0;
        end else begin
            if (wr_fire) begin
                if (wr_last) begin
                    full[wr_bank] <= 1'b1;
                    wr_idx        <= 6'd0;
                    wr_bank       <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + 6'd1;
                end
            end
            case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        state          <= EMIT;
                        valid_out      <= 1'b1;
                        column_out     <= load_data;
                        column_idx_out <= 3'd0;
                    end
                end
                EMIT: begin
                    if (out_ready_in) begin
                        if (column_idx_out == 3'd7) begin
                            full[rd_bank]  <= 1'b0;
                            rd_bank        <= ~rd_bank;
                            column_idx_out <= 3'd0;
                            // A block already waiting in the other bank follows with no bubble.
                            if (full[~rd_bank]) begin
                                column_out <= load_data;
                            end else begin
                                state     <= IDLE;
                                valid_out <= 1'b0;
                            end
                        end else begin
                            column_out     <= load_data;
                            column_idx_out <= column_idx_out + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dezigzag_buffer.sv
// Bench for dezigzag_buffer: random and directed blocks, scoreboard of expected columns.
// Expected columns come from a zigzag walk computed from diagonal order.
// A monitor checks every presented column, including held columns during stalls.
module tb_dezigzag_buffer;

    localparam int CW = 12;

    logic            clk_in = 1'b0;
    logic            rst_n_in;
    logic [CW-1:0]   coeff_in;
    logic            coeff_valid_in;
    logic            coeff_ready_out;
`ifdef DEZIGZAG_EOB_EN
    logic            eob_in;
`endif
    logic [8*CW-1:0] column_out;
    logic            valid_out;
    logic            out_ready_in;
    logic [2:0]      column_idx_out;

    dezigzag_buffer #(.COEFF_W(CW)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .coeff_in        (coeff_in),
        .coeff_valid_in  (coeff_valid_in),
`ifdef DEZIGZAG_EOB_EN
        .eob_in          (eob_in),
`endif
        .coeff_ready_out (coeff_ready_out),
        .column_out      (column_out),
        .valid_out       (valid_out),
        .out_ready_in    (out_ready_in),
        .column_idx_out  (column_idx_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [2:0]      idx;
        logic [8*CW-1:0] dat;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            passes = 0;
    int            popped = 0;
    int            ready_waits = 0;
    bit            done;
    int            zz_nat[64];
    logic [CW-1:0] blk[64];
    bit            blk_w[64];
    int            zcount = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic model_clear();
        zcount = 0;
        foreach (blk_w[i]) blk_w[i] = 1'b0;
    endtask

    // Reference: place by zigzag walk; a finished block becomes 8 columns, unwritten cells zero.
    task automatic model_accept(input logic [CW-1:0] v, input bit eob);
        exp_t e;
        blk[zz_nat[zcount]]   = v;
        blk_w[zz_nat[zcount]] = 1'b1;
        zcount++;
        if (eob || zcount == 64) begin
            for (int c = 0; c < 8; c++) begin
                e.idx = 3'(c);
                e.dat = '0;
                for (int r = 0; r < 8; r++)
                    if (blk_w[r*8+c]) e.dat[CW*r +: CW] = blk[r*8+c];
                exp_q.push_back(e);
            end
            model_clear();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [CW-1:0] v, input bit eob, input int gap);
        int t;
        repeat (gap) begin @(posedge clk_in); #1; end
        coeff_in       = v;
        coeff_valid_in = 1'b1;
`ifdef DEZIGZAG_EOB_EN
        eob_in         = eob;
`endif
        t = 0;
        @(negedge clk_in);
        while (!coeff_ready_out && t < 2000) begin
            ready_waits++;
            t++;
            @(negedge clk_in);
        end
        if (!coeff_ready_out) begin
            checks++;
            $display("FAIL send_timeout: coeff_ready_out=0 after 2000 cycles (required 1)");
        end else begin
            @(posedge clk_in);
            model_accept(v, eob);
        end
        #1;
        coeff_valid_in = 1'b0;
`ifdef DEZIGZAG_EOB_EN
        eob_in         = 1'b0;
`endif
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready_in = 1'b1;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk_in);
            t++;
        end
        repeat (3) @(posedge clk_in);
        #1;
        check("drain_empty", 128'(exp_q.size()), 128'd0);
        check("drain_valid_low", {127'd0, valid_out}, 128'd0);
    endtask

    // Monitor: compare every presented column with the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (rst_n_in === 1'b1 && valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_column: valid_out=1 idx=%0d (required valid_out=0)", column_idx_out);
                end else begin
                    e = exp_q[0];
                    check("col_data", {32'd0, column_out}, {32'd0, e.dat});
                    check("col_idx", {125'd0, column_idx_out}, {125'd0, e.idx});
                    if (out_ready_in) begin
                        void'(exp_q.pop_front());
                        popped++;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running (required finish)");
        $fatal(1);
    end

    initial begin
        int k, hi, a, bb, base;
        int c0[8];
        int c7[8];
        logic [8*CW-1:0] lit;

        k = 0;
        for (int s = 0; s < 15; s++) begin
            hi = (s < 8) ? s : 7;
            for (int i = 0; i < 8; i++) begin
                a  = hi - i;
                bb = s - a;
                if (a >= 0 && bb <= 7) begin
                    zz_nat[k] = (s % 2 == 0) ? a*8 + bb : bb*8 + a;
                    k++;
                end
            end
        end
        model_clear();

        rst_n_in       = 1'b0;
        coeff_in       = '0;
        coeff_valid_in = 1'b0;
        out_ready_in   = 1'b1;
`ifdef DEZIGZAG_EOB_EN
        eob_in         = 1'b0;
`endif
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_valid", {127'd0, valid_out}, 128'd0);
        check("rst_column", {32'd0, column_out}, 128'd0);
        check("rst_idx", {125'd0, column_idx_out}, 128'd0);
        check("rst_ready", {127'd0, coeff_ready_out}, 128'd1);
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;

        // Ramp block: latency and the literal first and last columns.
        for (int z = 0; z < 64; z++) send(CW'(z), 1'b0, 0);
        @(negedge clk_in);
        check("lat_not_yet", {127'd0, valid_out}, 128'd0);
        @(negedge clk_in);
        check("lat_valid", {127'd0, valid_out}, 128'd1);
        c0 = '{0, 2, 3, 9, 10, 20, 21, 35};
        c7 = '{28, 42, 43, 53, 54, 60, 61, 63};
        for (int r = 0; r < 8; r++) lit[CW*r +: CW] = CW'(c0[r]);
        check("ramp_col0", {32'd0, column_out}, {32'd0, lit});
        repeat (7) @(negedge clk_in);
        for (int r = 0; r < 8; r++) lit[CW*r +: CW] = CW'(c7[r]);
        check("ramp_col7", {32'd0, column_out}, {32'd0, lit});
        check("ramp_idx7", {125'd0, column_idx_out}, 128'd7);
        @(posedge clk_in);
        #1;
        drain();

        // Three random blocks back-to-back.
        ready_waits = 0;
        for (int n = 0; n < 3*64; n++) send(CW'($urandom), 1'b0, 0);
        check("b2b_ready_never_low", 128'(ready_waits), 128'd0);
        drain();

        // Stall while two blocks fill, then release.
        out_ready_in = 1'b0;
        for (int n = 0; n < 2*64; n++) send(CW'($urandom), 1'b0, 0);
        @(negedge clk_in);
        check("stall_ready_low", {127'd0, coeff_ready_out}, 128'd0);
        @(posedge clk_in);
        #1 out_ready_in = 1'b1;
        repeat (7) @(posedge clk_in);
        #2;
        check("ready_before_a7", {127'd0, coeff_ready_out}, 128'd0);
        @(posedge clk_in);
        #2;
        check("ready_after_a7", {127'd0, coeff_ready_out}, 128'd1);
        repeat (8) @(posedge clk_in);
        #2;
        check("no_bubble_empty", 128'(exp_q.size()), 128'd0);
        check("no_bubble_idle", {127'd0, valid_out}, 128'd0);
        @(posedge clk_in);
        #1;
        drain();

        // Reset with one pending block and a partial one.
        out_ready_in = 1'b0;
        for (int n = 0; n < 64 + 30; n++) send(CW'($urandom), 1'b0, 0);
        rst_n_in = 1'b0;
        exp_q.delete();
        model_clear();
        @(negedge clk_in);
        check("midrst_valid", {127'd0, valid_out}, 128'd0);
        check("midrst_ready", {127'd0, coeff_ready_out}, 128'd1);
        check("midrst_column", {32'd0, column_out}, 128'd0);
        @(posedge clk_in);
        #1;
        rst_n_in     = 1'b1;
        out_ready_in = 1'b1;
        base = popped;
        for (int n = 0; n < 64; n++) send(12'hFFF, 1'b0, 0);
        drain();
        check("rst_block_cols", 128'(popped - base), 128'd8);

        // Random gaps on both sides.
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 4*64; n++) send(CW'($urandom), 1'b0, $urandom_range(0, 2));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk_in);
                    #1 out_ready_in = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();

`ifdef DEZIGZAG_EOB_EN
        // Short block after a saturated one: stale cells must read zero.
        for (int n = 0; n < 64; n++) send(12'h7FF, 1'b0, 0);
        send(12'd100, 1'b0, 0);
        send(12'hFF9, 1'b0, 0);
        send(12'd4, 1'b1, 0);
        drain();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
